// File: rtl/branch_pred_pkg.sv
// Shared sizing and entry record for the branch outcome tracker and its
// in-flight prediction queue.
package branch_pred_pkg;

  localparam int LOWER = 5;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [LOWER-1:0] addr;
    logic             pred;
  } pred_entry_t;

endpackage

// File: rtl/pred_fifo.sv
// Age-ordered queue of in-flight predictions; clear empties it in one cycle
// and wins over any push or pop presented alongside it.
module pred_fifo
  import branch_pred_pkg::*;
(
  input  logic        clk,
  input  logic        arst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_clear,
  input  pred_entry_t i_din,
  output pred_entry_t o_head,
  output logic        o_full,
  output logic        o_empty
);

  pred_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload is only meaningful between head and tail, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_tail] <= i_din;
  end

  assign o_head  = r_mem[r_head];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/branch_outcome_tracker.sv
// Matches execute-stage outcomes against queued fetch predictions, emits the
// history-table update and flush strobes, and keeps saturating statistics.
module branch_outcome_tracker
  import branch_pred_pkg::pred_entry_t;
  import branch_pred_pkg::STAT_MAX;
#(
  parameter int LOWER = branch_pred_pkg::LOWER,
  parameter int DEPTH = branch_pred_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             pred_valid,
  input  logic [LOWER-1:0] pred_addr,
  input  logic             prediction,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic             res_jump,
  output logic             upd_en,
  output logic [LOWER-1:0] upd_addr,
  output logic             upd_was_taken,
  output logic             upd_jumped,
  output logic             mispredict,
  output logic             full,
  output logic             empty,
  output logic             underflow_err,
  output logic [15:0]      branch_cnt,
  output logic [15:0]      mispred_cnt
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == STAT_MAX) ? v : v + 16'd1;
  endfunction

  pred_entry_t      w_din;
  pred_entry_t      w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_actual;
  logic             w_pop;
  logic             w_mispred;
  logic             w_push;

  logic             r_upd_en;
  logic [LOWER-1:0] r_upd_addr;
  logic             r_upd_was_taken;
  logic             r_upd_jumped;
  logic             r_mispredict;
  logic             r_underflow_err;
  logic [15:0]      r_branch_cnt;
  logic [15:0]      r_mispred_cnt;

  assign w_actual  = res_taken | res_jump;
  assign w_pop     = res_valid & ~w_empty;
  assign w_mispred = w_pop & (w_actual != w_head.pred);
  // A full queue only takes a push when a correct pop frees a slot that edge;
  // a flush discards the incoming branch along with everything younger.
  assign w_push    = pred_valid & ~w_mispred & (~w_full | w_pop);

  assign w_din.addr = pred_addr;
  assign w_din.pred = prediction;

  pred_fifo u_pred_fifo (
    .clk     (clk),
    .arst    (arst),
    .i_push  (w_push),
    .i_pop   (w_pop & ~w_mispred),
    .i_clear (w_mispred),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_upd_en        <= 1'b0;
      r_upd_addr      <= '0;
      r_upd_was_taken <= 1'b0;
      r_upd_jumped    <= 1'b0;
      r_mispredict    <= 1'b0;
      r_underflow_err <= 1'b0;
      r_branch_cnt    <= '0;
      r_mispred_cnt   <= '0;
    end else begin
      r_upd_en     <= w_pop;
      r_mispredict <= w_mispred;
      if (w_pop) begin
        r_upd_addr      <= w_head.addr;
        r_upd_was_taken <= res_taken;
        r_upd_jumped    <= res_jump;
        r_branch_cnt    <= sat_inc(r_branch_cnt);
      end
      if (w_mispred) r_mispred_cnt <= sat_inc(r_mispred_cnt);
      if (res_valid && w_empty) r_underflow_err <= 1'b1;
    end
  end

  assign upd_en        = r_upd_en;
  assign upd_addr      = r_upd_addr;
  assign upd_was_taken = r_upd_was_taken;
  assign upd_jumped    = r_upd_jumped;
  assign mispredict    = r_mispredict;
  assign underflow_err = r_underflow_err;
  assign branch_cnt    = r_branch_cnt;
  assign mispred_cnt   = r_mispred_cnt;
  assign full          = w_full;
  assign empty         = w_empty;

endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Directed bench for branch_outcome_tracker with a queue-based reference model.
module tb_branch_outcome_tracker;

  localparam int LOWER = 5;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             arst;
  logic             pred_valid;
  logic [LOWER-1:0] pred_addr;
  logic             prediction;
  logic             res_valid;
  logic             res_taken;
  logic             res_jump;
  logic             upd_en;
  logic [LOWER-1:0] upd_addr;
  logic             upd_was_taken;
  logic             upd_jumped;
  logic             mispredict;
  logic             full;
  logic             empty;
  logic             underflow_err;
  logic [15:0]      branch_cnt;
  logic [15:0]      mispred_cnt;

  branch_outcome_tracker #(.LOWER(LOWER), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .arst          (arst),
    .pred_valid    (pred_valid),
    .pred_addr     (pred_addr),
    .prediction    (prediction),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .res_jump      (res_jump),
    .upd_en        (upd_en),
    .upd_addr      (upd_addr),
    .upd_was_taken (upd_was_taken),
    .upd_jumped    (upd_jumped),
    .mispredict    (mispredict),
    .full          (full),
    .empty         (empty),
    .underflow_err (underflow_err),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LOWER-1:0] addr;
    logic             pred;
  } ent_t;

  ent_t             q[$];
  logic             m_upd_en;
  logic             m_mis;
  logic             m_was;
  logic             m_jmp;
  logic             m_uf;
  logic [LOWER-1:0] m_addr;
  int               m_bc;
  int               m_mc;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_upd_en = 1'b0;
    m_mis    = 1'b0;
    m_was    = 1'b0;
    m_jmp    = 1'b0;
    m_uf     = 1'b0;
    m_addr   = '0;
    m_bc     = 0;
    m_mc     = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int sz;
    bit pop;
    bit mis;
    sz  = q.size();
    pop = res_valid && (sz > 0);
    mis = 1'b0;
    if (res_valid && sz == 0) m_uf = 1'b1;
    m_upd_en = pop;
    m_mis    = 1'b0;
    if (pop) begin
      ent_t e;
      bit   act;
      e      = q.pop_front();
      act    = res_taken | res_jump;
      m_addr = e.addr;
      m_was  = res_taken;
      m_jmp  = res_jump;
      if (m_bc < 65535) m_bc++;
      if (act != e.pred) begin
        mis   = 1'b1;
        m_mis = 1'b1;
        q.delete();
        if (m_mc < 65535) m_mc++;
      end
    end
    if (pred_valid && !mis && (sz < DEPTH || pop)) begin
      ent_t n;
      n.addr = pred_addr;
      n.pred = prediction;
      q.push_back(n);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("upd_en",        32'(upd_en),        32'(m_upd_en));
      check("mispredict",    32'(mispredict),    32'(m_mis));
      check("upd_addr",      32'(upd_addr),      32'(m_addr));
      check("upd_was_taken", 32'(upd_was_taken), 32'(m_was));
      check("upd_jumped",    32'(upd_jumped),    32'(m_jmp));
      check("full",          32'(full),          32'(q.size() == DEPTH));
      check("empty",         32'(empty),         32'(q.size() == 0));
      check("underflow_err", 32'(underflow_err), 32'(m_uf));
      check("branch_cnt",    32'(branch_cnt),    32'(m_bc));
      check("mispred_cnt",   32'(mispred_cnt),   32'(m_mc));
    end
  end

  task automatic cyc(input logic pv, input logic [LOWER-1:0] pa, input logic pr,
                     input logic rv, input logic rt, input logic rj);
    pred_valid = pv;
    pred_addr  = pa;
    prediction = pr;
    res_valid  = rv;
    res_taken  = rt;
    res_jump   = rj;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1;
    pred_valid = 1'b0; pred_addr = '0; prediction = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0; res_jump = 1'b0;
    model_reset();
    #12;
    check("rst_upd_en",  32'(upd_en),      32'd0);
    check("rst_empty",   32'(empty),       32'd1);
    check("rst_full",    32'(full),        32'd0);
    check("rst_bcnt",    32'(branch_cnt),  32'd0);
    check("rst_mcnt",    32'(mispred_cnt), 32'd0);
    chk_en = 1'b1;
    @(negedge clk);
    arst = 1'b0;

    // Correctly predicted taken branch.
    cyc(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t1_upd_en",   32'(upd_en),        32'd1);
    check("t1_upd_addr", 32'(upd_addr),      32'd5);
    check("t1_taken",    32'(upd_was_taken), 32'd1);
    check("t1_mispred",  32'(mispredict),    32'd0);
    check("t1_bcnt",     32'(branch_cnt),    32'd1);
    idle();
    check("t1_strobe_end", 32'(upd_en), 32'd0);

    // Misprediction flushes the younger entry 7.
    cyc(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t2_mispred",  32'(mispredict),  32'd1);
    check("t2_upd_addr", 32'(upd_addr),    32'd3);
    check("t2_empty",    32'(empty),       32'd1);
    check("t2_mcnt",     32'(mispred_cnt), 32'd1);
    idle();
    check("t2_no_upd",   32'(upd_en),      32'd0);
    check("t2_mis_end",  32'(mispredict),  32'd0);

    // Fill, dropped push, then push alongside a correct pop.
    for (int i = 0; i < 4; i++) cyc(1'b1, 5'(10 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_full", 32'(full), 32'd1);
    cyc(1'b1, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_drop_full", 32'(full), 32'd1);
    cyc(1'b1, 5'd21, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t3_pp_addr", 32'(upd_addr), 32'd10);
    check("t3_pp_full", 32'(full),     32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t3_pop11", 32'(upd_addr), 32'd11);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t3_pop12",  32'(upd_addr),   32'd12);
    check("t3_jumped", 32'(upd_jumped), 32'd1);
    check("t3_jmp_nt", 32'(upd_was_taken), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t3_pop13", 32'(upd_addr), 32'd13);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t3_pop21", 32'(upd_addr), 32'd21);
    check("t3_empty", 32'(empty),    32'd1);

    // Push on the same edge as a mispredicting pop is discarded.
    cyc(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t3b_mispred", 32'(mispredict), 32'd1);
    check("t3b_empty",   32'(empty),      32'd1);
    idle();

    // Resolve while empty.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_upd_en",  32'(upd_en),        32'd0);
    check("t4_mispred", 32'(mispredict),    32'd0);
    check("t4_uflow",   32'(underflow_err), 32'd1);
    repeat (3) idle();
    check("t4_sticky",  32'(underflow_err), 32'd1);

    // Saturate the misprediction counter.
    for (int i = 0; i < 65536; i++) begin
      cyc(1'b1, 5'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    check("t5_mcnt_sat", 32'(mispred_cnt), 32'hFFFF);
    check("t5_bcnt_sat", 32'(branch_cnt),  32'hFFFF);

    // Reset with entries queued and an update strobe pending.
    for (int i = 0; i < 3; i++) cyc(1'b1, 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_pre_upd", 32'(upd_en), 32'd1);
    pred_valid = 1'b0; res_valid = 1'b0;
    arst = 1'b1;
    model_reset();
    #1;
    check("t6_upd_en", 32'(upd_en),        32'd0);
    check("t6_empty",  32'(empty),         32'd1);
    check("t6_bcnt",   32'(branch_cnt),    32'd0);
    check("t6_mcnt",   32'(mispred_cnt),   32'd0);
    check("t6_uflow",  32'(underflow_err), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    cyc(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_push_ok", 32'(empty), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_upd_addr", 32'(upd_addr), 32'd2);
    idle();

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_outcome_tracker.md
BRANCH_OUTCOME_TRACKER -- requirements
Module: branch_outcome_tracker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and arst as in the codebase (the polarity and synchronicity are fixed).
REQ-002 Parameter LOWER, default 5, SHALL be the number of PC low bits indexing the branch history table.
REQ-003 Parameter DEPTH, default 4 (power of two), SHALL be the number of in-flight predicted branches.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 arst  in  1  async active-high reset.
REQ-006 pred_valid  in  1  fetch stage issues a branch whose prediction is now known.
REQ-007 pred_addr  in  LOWER  PC low bits of that branch.
REQ-008 prediction  in  1  taken prediction returned by the history table.
REQ-009 res_valid  in  1  execute stage resolves the oldest in-flight branch.
REQ-010 res_taken  in  1  conditional branch was taken.
REQ-011 res_jump  in  1  unconditional jump executed.
REQ-012 upd_en  out  1  history-table update strobe.
REQ-013 upd_addr  out  LOWER  update address.
REQ-014 upd_was_taken, upd_jumped  out  1 each  update outcome bits.
REQ-015 mispredict  out  1  one-cycle flush/redirect request.
REQ-016 full, empty  out  1 each  queue status.
REQ-017 underflow_err  out  1  sticky; set by resolve while empty.
REQ-018 branch_cnt, mispred_cnt  out  16 each  saturating statistics counters.

Function
REQ-019 The block SHALL hold DEPTH entries {addr, prediction} in age order, with a head pointer, a tail pointer and a count of log2(DEPTH)+1 bits; the pointers SHALL wrap modulo DEPTH.
REQ-020 A push SHALL occur when pred_valid=1 and (full=0, or full=1 with a simultaneous non-mispredicting pop); a push while full without a pop SHALL be dropped and the state SHALL be left unchanged.
REQ-021 A pop SHALL occur when res_valid=1 and empty=0; actual SHALL equal res_taken OR res_jump.
REQ-022 One cycle after a pop, upd_en SHALL be 1 for exactly one cycle, with upd_addr=head.addr, upd_was_taken=res_taken and upd_jumped=res_jump.
REQ-023 One cycle after a pop with actual != head.prediction, mispredict SHALL be 1 for exactly one cycle.
REQ-024 In a mispredicting pop cycle, all younger entries SHALL be discarded, any same-cycle push SHALL be discarded, and the queue SHALL be empty on the next cycle.
REQ-025 A simultaneous push and non-mispredicting pop SHALL keep the count unchanged.
REQ-026 res_valid while empty SHALL cause no pop, no upd_en and no mispredict, and SHALL set underflow_err, which stays set until reset.
REQ-027 branch_cnt SHALL increment on each pop and mispred_cnt on each mispredicting pop; both SHALL saturate at 16'hFFFF.
REQ-028 full and empty SHALL be registered-state decodes of count, valid in the same cycle as the count.

Reset
REQ-029 On arst=1 the block SHALL asynchronously clear head, tail, count, both counters and underflow_err, and drive upd_en=0, mispredict=0, upd_addr=0, upd_was_taken=0, upd_jumped=0, empty=1 and full=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight entries and pending strobes; the first push after release SHALL be accepted.

Structure
REQ-031 LOWER, DEPTH, the count width and the queue entry record type SHALL live in a shared package branch_pred_pkg.
REQ-032 Storage and pointers SHALL be a sub-module pred_fifo (push, pop, clear, full, empty, head data); comparison, update outputs and counters SHALL remain in the top module.

Verification
REQ-033 Push addr=5,pred=1; then res_valid with taken=1 -> next cycle upd_en=1, upd_addr=5, upd_was_taken=1, mispredict=0, branch_cnt=1.
REQ-034 Push addr=3,pred=0 and addr=7,pred=1; resolve taken=1 -> mispredict=1 and upd_addr=3; next cycle empty=1, mispred_cnt=1, and entry 7 is never updated.
REQ-035 Four pushes to fill (full=1); fifth push alone is dropped; fifth push with a correct pop in the same cycle -> count stays 4 and pop order stays FIFO.
REQ-036 res_valid on empty -> upd_en=0, mispredict=0, underflow_err=1 held until arst.
REQ-037 Preload mispred_cnt near saturation via 65536 mispredictions -> mispred_cnt stays 16'hFFFF.
REQ-038 Assert arst with 3 entries queued and a pop in flight -> upd_en=0 immediately, empty=1, counters=0.
